// File: rtl/score_keeper.sv
// Run score, session high score, speed level and new-record flash for the game.
// Driven by the player controller's tick/start/over/frozen outputs; all outputs registered.
module score_keeper #(
    parameter int NUM_DIGITS      = 4,
    parameter int TICKS_PER_POINT = 6,
    parameter int LEVEL_POINTS    = 100,
    parameter int MAX_LEVEL       = 7,
    parameter int FLASH_TICKS     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [1:0]              game_tick_i,
    input  logic                    game_start_pulse_i,
    input  logic                    game_over_pulse_i,
    input  logic                    game_frozen_i,
    output logic [4*NUM_DIGITS-1:0] score_bcd_o,
    output logic [4*NUM_DIGITS-1:0] high_score_bcd_o,
    output logic [2:0]              speed_level_o,
    output logic                    new_high_o,
    output logic                    new_high_flash_o
);

    // state    | meaning
    // ST_IDLE  | after reset, waiting for the first start pulse
    // ST_RUN   | game running, score and level advance on ticks
    // ST_OVER  | crashed, score held, optional record flash
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    localparam int SW = 4 * NUM_DIGITS;
    localparam int PW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
    localparam int LW = (LEVEL_POINTS > 1) ? $clog2(LEVEL_POINTS) : 1;
    localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

    // Timers count down and fire at zero; the load value is the "cleared" state.
    localparam logic [PW-1:0] PRESC_LOAD = PW'(TICKS_PER_POINT - 1);
    localparam logic [LW-1:0] LVL_LOAD   = LW'(LEVEL_POINTS - 1);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_TICKS - 1);
    localparam logic [2:0]    LEVEL_MAX  = 3'(MAX_LEVEL);

    function automatic logic [SW-1:0] all_nines();
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    localparam logic [SW-1:0] ALL_NINES = all_nines();

    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [SW-1:0] score_q, score_d;
    logic [SW-1:0] high_q, high_d;
    logic [2:0]    level_q, level_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [LW-1:0] lvl_cnt_q, lvl_cnt_d;
    logic [FW-1:0] flash_cnt_q, flash_cnt_d;
    logic          new_high_q, new_high_d;
    logic          flash_q, flash_d;

    logic tick;
    logic unused_tick_hi;

    assign tick           = game_tick_i[0];
    assign unused_tick_hi = game_tick_i[1];

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        high_d      = high_q;
        level_d     = level_q;
        presc_d     = presc_q;
        lvl_cnt_d   = lvl_cnt_q;
        flash_cnt_d = flash_cnt_q;
        new_high_d  = new_high_q;
        flash_d     = flash_q;

        case (state_q)
            ST_IDLE: begin
                if (game_start_pulse_i) begin
                    state_d     = ST_RUN;
                    score_d     = '0;
                    level_d     = '0;
                    presc_d     = PRESC_LOAD;
                    lvl_cnt_d   = LVL_LOAD;
                    flash_cnt_d = FLASH_LOAD;
                    new_high_d  = 1'b0;
                    flash_d     = 1'b0;
                end
            end
            ST_RUN: begin
                if (game_over_pulse_i) begin
                    // The crash takes priority; a coincident scoring tick is dropped.
                    state_d     = ST_OVER;
                    flash_cnt_d = FLASH_LOAD;
                    if (score_q > high_q) begin
                        high_d     = score_q;
                        new_high_d = 1'b1;
                        flash_d    = 1'b1;
                    end else begin
                        new_high_d = 1'b0;
                        flash_d    = 1'b0;
                    end
                end else if (tick && !game_frozen_i) begin
                    if (presc_q == '0) begin
                        presc_d = PRESC_LOAD;
                        if (score_q != ALL_NINES) begin
                            score_d = bcd_inc(score_q);
                            if (lvl_cnt_q == '0) begin
                                lvl_cnt_d = LVL_LOAD;
                                if (level_q < LEVEL_MAX) begin
                                    level_d = level_q + 3'd1;
                                end
                            end else begin
                                lvl_cnt_d = lvl_cnt_q - LW'(1);
                            end
                        end
                    end else begin
                        presc_d = presc_q - PW'(1);
                    end
                end
            end
            ST_OVER: begin
                if (game_start_pulse_i) begin
                    state_d     = ST_RUN;
                    score_d     = '0;
                    level_d     = '0;
                    presc_d     = PRESC_LOAD;
                    lvl_cnt_d   = LVL_LOAD;
                    flash_cnt_d = FLASH_LOAD;
                    new_high_d  = 1'b0;
                    flash_d     = 1'b0;
                end else if (tick && new_high_q) begin
                    // Blink keeps going while frozen: the game is always frozen here.
                    if (flash_cnt_q == '0) begin
                        flash_cnt_d = FLASH_LOAD;
                        flash_d     = ~flash_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q - FW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            high_q      <= '0;
            level_q     <= '0;
            presc_q     <= '0;
            lvl_cnt_q   <= '0;
            flash_cnt_q <= '0;
            new_high_q  <= 1'b0;
            flash_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            high_q      <= high_d;
            level_q     <= level_d;
            presc_q     <= presc_d;
            lvl_cnt_q   <= lvl_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            new_high_q  <= new_high_d;
            flash_q     <= flash_d;
        end
    end

    assign score_bcd_o      = score_q;
    assign high_score_bcd_o = high_q;
    assign speed_level_o    = level_q;
    assign new_high_o       = new_high_q;
    assign new_high_flash_o = flash_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: a vector table on the default build plus a
// small-parameter instance for digit/level saturation and short flash period.
module tb_score_keeper;

    logic        clk;
    logic        rst;
    logic [1:0]  tick;
    logic        start, over, frozen;
    logic [15:0] score, high;
    logic [2:0]  lvl;
    logic        nh, fl;

    logic        s_rst;
    logic [1:0]  s_tick;
    logic        s_start, s_over, s_frozen;
    logic [7:0]  s_score, s_high;
    logic [2:0]  s_lvl;
    logic        s_nh, s_fl;

    int checks = 0;
    int errors = 0;

    score_keeper dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .game_tick_i        (tick),
        .game_start_pulse_i (start),
        .game_over_pulse_i  (over),
        .game_frozen_i      (frozen),
        .score_bcd_o        (score),
        .high_score_bcd_o   (high),
        .speed_level_o      (lvl),
        .new_high_o         (nh),
        .new_high_flash_o   (fl)
    );

    score_keeper #(
        .NUM_DIGITS      (2),
        .TICKS_PER_POINT (1),
        .LEVEL_POINTS    (10),
        .MAX_LEVEL       (7),
        .FLASH_TICKS     (2)
    ) u_sat (
        .clk_i              (clk),
        .rst_i              (s_rst),
        .game_tick_i        (s_tick),
        .game_start_pulse_i (s_start),
        .game_over_pulse_i  (s_over),
        .game_frozen_i      (s_frozen),
        .score_bcd_o        (s_score),
        .high_score_bcd_o   (s_high),
        .speed_level_o      (s_lvl),
        .new_high_o         (s_nh),
        .new_high_flash_o   (s_fl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        over;
        logic        frozen;
        logic [1:0]  tick;
        int          cyc;
        logic [15:0] score;
        logic [15:0] high;
        logic [2:0]  lvl;
        logic        nh;
        logic        fl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic o, input logic f,
                                input logic [1:0] t, input int c, input logic [15:0] sc,
                                input logic [15:0] hi, input logic [2:0] lv, input logic n,
                                input logic fla);
        vec_t v;
        v.rst = r; v.start = s; v.over = o; v.frozen = f; v.tick = t; v.cyc = c;
        v.score = sc; v.high = hi; v.lvl = lv; v.nh = n; v.fl = fla;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic s_step(input string name, input logic st, input logic ov, input int cyc,
                          input logic [7:0] e_sc, input logic [7:0] e_hi, input logic [2:0] e_lv,
                          input logic e_nh, input logic e_fl);
        for (int k = 0; k < cyc; k++) begin
            @(negedge clk);
            s_start = st; s_over = ov; s_tick = 2'b01;
        end
        @(negedge clk);
        s_start = 1'b0; s_over = 1'b0; s_tick = 2'b00;
        chk({name, " score"}, {8'h0, s_score}, {8'h0, e_sc});
        chk({name, " high"},  {8'h0, s_high},  {8'h0, e_hi});
        chk({name, " level"}, {13'h0, s_lvl},  {13'h0, e_lv});
        chk({name, " new_high"}, {15'h0, s_nh}, {15'h0, e_nh});
        chk({name, " flash"}, {15'h0, s_fl},   {15'h0, e_fl});
    endtask

    initial begin
        rst = 1'b0; tick = 2'b00; start = 1'b0; over = 1'b0; frozen = 1'b0;
        s_rst = 1'b0; s_tick = 2'b00; s_start = 1'b0; s_over = 1'b0; s_frozen = 1'b0;

        //          rst  st   ov   fz   tick   cyc  score    high     lv  nh fl
        vecs.push_back(mk(1, 0, 0, 0, 2'b00,   2, 16'h0000, 16'h0000, 0, 0, 0)); // 0 reset
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,   5, 16'h0000, 16'h0000, 0, 0, 0)); // 1 idle ticks
        vecs.push_back(mk(0, 0, 1, 0, 2'b01,   1, 16'h0000, 16'h0000, 0, 0, 0)); // 2 over in idle
        vecs.push_back(mk(0, 1, 0, 0, 2'b01,   1, 16'h0000, 16'h0000, 0, 0, 0)); // 3 start
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,  60, 16'h0010, 16'h0000, 0, 0, 0)); // 4 60 ticks
        vecs.push_back(mk(0, 0, 0, 0, 2'b10,  12, 16'h0010, 16'h0000, 0, 0, 0)); // 5 bit1 ignored
        vecs.push_back(mk(0, 0, 0, 1, 2'b01,  12, 16'h0010, 16'h0000, 0, 0, 0)); // 6 frozen
        vecs.push_back(mk(0, 0, 0, 0, 2'b01, 534, 16'h0099, 16'h0000, 0, 0, 0)); // 7 to 99
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,   6, 16'h0100, 16'h0000, 1, 0, 0)); // 8 carry, level
        vecs.push_back(mk(0, 1, 0, 0, 2'b01,   1, 16'h0100, 16'h0000, 1, 0, 0)); // 9 start in run
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,   5, 16'h0101, 16'h0000, 1, 0, 0)); // 10
        vecs.push_back(mk(1, 0, 0, 0, 2'b00,   1, 16'h0000, 16'h0000, 0, 0, 0)); // 11 rst in run
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,   6, 16'h0000, 16'h0000, 0, 0, 0)); // 12 idle again
        vecs.push_back(mk(0, 1, 0, 0, 2'b00,   1, 16'h0000, 16'h0000, 0, 0, 0)); // 13 start
        vecs.push_back(mk(0, 0, 0, 0, 2'b01, 252, 16'h0042, 16'h0000, 0, 0, 0)); // 14 to 42
        vecs.push_back(mk(0, 0, 1, 0, 2'b01,   1, 16'h0042, 16'h0042, 0, 1, 1)); // 15 record
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,  15, 16'h0042, 16'h0042, 0, 1, 1)); // 16
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,   1, 16'h0042, 16'h0042, 0, 1, 0)); // 17 16th tick
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,  16, 16'h0042, 16'h0042, 0, 1, 1)); // 18
        vecs.push_back(mk(0, 0, 1, 0, 2'b01,   1, 16'h0042, 16'h0042, 0, 1, 1)); // 19 over in over
        vecs.push_back(mk(0, 1, 0, 0, 2'b00,   1, 16'h0000, 16'h0042, 0, 0, 0)); // 20 restart
        vecs.push_back(mk(0, 0, 0, 0, 2'b01, 252, 16'h0042, 16'h0042, 0, 0, 0)); // 21
        vecs.push_back(mk(0, 0, 1, 0, 2'b01,   1, 16'h0042, 16'h0042, 0, 0, 0)); // 22 equal
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,  20, 16'h0042, 16'h0042, 0, 0, 0)); // 23 no flash
        vecs.push_back(mk(0, 1, 0, 0, 2'b01,   1, 16'h0000, 16'h0042, 0, 0, 0)); // 24 restart
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,  35, 16'h0005, 16'h0042, 0, 0, 0)); // 25
        vecs.push_back(mk(0, 0, 1, 0, 2'b01,   1, 16'h0005, 16'h0042, 0, 0, 0)); // 26 over wins
        vecs.push_back(mk(0, 1, 0, 0, 2'b00,   1, 16'h0000, 16'h0042, 0, 0, 0)); // 27 restart
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,   6, 16'h0001, 16'h0042, 0, 0, 0)); // 28 presc clr
        vecs.push_back(mk(0, 0, 1, 0, 2'b01,   1, 16'h0001, 16'h0042, 0, 0, 0)); // 29
        vecs.push_back(mk(1, 0, 0, 0, 2'b00,   1, 16'h0000, 16'h0000, 0, 0, 0)); // 30 rst clears high
        vecs.push_back(mk(0, 0, 0, 0, 2'b01,   6, 16'h0000, 16'h0000, 0, 0, 0)); // 31

        for (int i = 0; i < vecs.size(); i++) begin
            for (int k = 0; k < vecs[i].cyc; k++) begin
                @(negedge clk);
                rst    = vecs[i].rst;
                start  = vecs[i].start;
                over   = vecs[i].over;
                frozen = vecs[i].frozen;
                tick   = vecs[i].tick;
            end
            @(negedge clk);
            rst = 1'b0; start = 1'b0; over = 1'b0; frozen = 1'b0; tick = 2'b00;
            chk($sformatf("v%0d score", i),    score,          vecs[i].score);
            chk($sformatf("v%0d high", i),     high,           vecs[i].high);
            chk($sformatf("v%0d level", i),    {13'h0, lvl},   {13'h0, vecs[i].lvl});
            chk($sformatf("v%0d new_high", i), {15'h0, nh},    {15'h0, vecs[i].nh});
            chk($sformatf("v%0d flash", i),    {15'h0, fl},    {15'h0, vecs[i].fl});
        end

        // Two-digit instance: one point per tick, level every 10 points, cap at 7.
        @(negedge clk);
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        s_step("s_start",  1'b1, 1'b0,  1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        s_step("s_9",      1'b0, 1'b0,  9, 8'h09, 8'h00, 3'd0, 1'b0, 1'b0);
        s_step("s_10",     1'b0, 1'b0,  1, 8'h10, 8'h00, 3'd1, 1'b0, 1'b0);
        s_step("s_69",     1'b0, 1'b0, 59, 8'h69, 8'h00, 3'd6, 1'b0, 1'b0);
        s_step("s_70",     1'b0, 1'b0,  1, 8'h70, 8'h00, 3'd7, 1'b0, 1'b0);
        s_step("s_99",     1'b0, 1'b0, 29, 8'h99, 8'h00, 3'd7, 1'b0, 1'b0);
        s_step("s_sat",    1'b0, 1'b0, 20, 8'h99, 8'h00, 3'd7, 1'b0, 1'b0);
        s_step("s_over",   1'b0, 1'b1,  1, 8'h99, 8'h99, 3'd7, 1'b1, 1'b1);
        s_step("s_fl1",    1'b0, 1'b0,  1, 8'h99, 8'h99, 3'd7, 1'b1, 1'b1);
        s_step("s_fl2",    1'b0, 1'b0,  1, 8'h99, 8'h99, 3'd7, 1'b1, 1'b0);
        s_step("s_restart",1'b1, 1'b0,  1, 8'h00, 8'h99, 3'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
